l1_line_controller: RTL



---
 rtl/l1_line_controller_pkg.sv | 39 +++
 rtl/l1_line_controller_if.sv | 38 +++
 rtl/l1_line_controller_array.sv | 48 ++++
 rtl/l1_line_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1_line_controller_pkg.sv
// Shared constants, FSM state type and pending-access record for the L1 line controller.
package l1_line_controller_pkg;

    localparam int unsigned LINE_BYTES = 128;
    localparam int unsigned LINE_BITS  = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        WR_REQ,
        FILL
    } ctrl_state_e;

    // Access parked while the arbiter repairs the missing line.
    typedef struct packed {
        logic [31:0]           addr;
        logic                  is_write;
        logic [LINE_BITS-1:0]  wdata;
        logic [LINE_BYTES-1:0] wmask;
        logic                  fill_seen;
    } pend_req_t;

    // Byte-wise merge: bytes with mask set come from new_line, the rest from old_line.
    function automatic logic [LINE_BITS-1:0] byte_merge(
        input logic [LINE_BITS-1:0]  old_line,
        input logic [LINE_BITS-1:0]  new_line,
        input logic [LINE_BYTES-1:0] mask
    );
        logic [LINE_BITS-1:0] merged;
        merged = old_line;
        for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_line[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/l1_line_controller_if.sv
// Arbiter/controller link: access channels, repair handshake and read response.
interface l1_line_controller_if;
    import l1_line_controller_pkg::*;

    logic                  raddr_valid;
    logic [31:0]           raddr;
    logic                  waddr_valid;
    logic [31:0]           waddr;
    logic [LINE_BITS-1:0]  wdata;
    logic [LINE_BYTES-1:0] wmask;
    logic                  sent_repair;
    logic                  read_repair_req_acq;
    logic                  write_repair_req_acq;
    logic                  repair_resolved;
    logic [31:0]           rdata;
    logic                  rdata_valid;
    logic                  read_repair_request;
    logic                  write_repair_request;
    logic [31:0]           missed_raddr;
    logic [31:0]           missed_waddr;

    // Arbiter side
    modport master (
        output raddr_valid, raddr, waddr_valid, waddr, wdata, wmask, sent_repair,
               read_repair_req_acq, write_repair_req_acq, repair_resolved,
        input  rdata, rdata_valid, read_repair_request, write_repair_request,
               missed_raddr, missed_waddr
    );

    // Controller side
    modport slave (
        input  raddr_valid, raddr, waddr_valid, waddr, wdata, wmask, sent_repair,
               read_repair_req_acq, write_repair_req_acq, repair_resolved,
        output rdata, rdata_valid, read_repair_request, write_repair_request,
               missed_raddr, missed_waddr
    );

endinterface

// File: rtl/l1_line_controller_array.sv
// Direct-mapped tag/valid/data store: combinational lookup, one synchronous byte-masked write port.
module l1_line_array
    import l1_line_controller_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned TAG_W     = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_valid,
    output logic [LINE_BITS-1:0]  o_line,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [TAG_W-1:0]      i_wtag,
    input  logic [LINE_BITS-1:0]  i_wdata,
    input  logic [LINE_BYTES-1:0] i_wmask,
    input  logic                  i_full
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    // Valid bits: cleared on reset, set by any write to the line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    // Tag and data storage; a full-line write ignores the byte mask
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_full ? i_wdata : byte_merge(r_data[i_widx], i_wdata, i_wmask);
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_line  = r_data[i_ridx];

endmodule

// File: rtl/l1_line_controller.sv
// Controller end of the arbiter link: direct-mapped write-allocate line store with miss repair and replay.
module l1_line_controller #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_BYTES = 128,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_line_controller_if.slave  bus
);
    import l1_line_controller_pkg::*;

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

    ctrl_state_e  r_state;
    pend_req_t    r_pend;
    logic [31:0]  r_rdata;
    logic         r_rdata_valid;
    logic         r_rd_req;
    logic         r_wr_req;
    logic [31:0]  r_missed_raddr;
    logic [31:0]  r_missed_waddr;

    logic [ADDR_W-1:OFF_W]  w_acc_addr;
    logic [IDX_W-1:0]       w_acc_idx;
    logic [TAG_W-1:0]       w_acc_tag;
    logic [IDX_W-1:0]       w_pend_idx;
    logic [TAG_W-1:0]       w_pend_tag;
    logic [IDX_W-1:0]       w_fill_idx;
    logic [TAG_W-1:0]       w_fill_tag;
    logic [TAG_W-1:0]       w_lk_tag;
    logic                   w_lk_valid;
    logic [LINE_BITS-1:0]   w_lk_line;
    logic [LINE_BITS-1:0]   w_src_line;
    logic [OFF_W-3:0]       w_word_sel;
    logic [31:0]            w_word;
    logic                   w_hit;
    logic                   w_wr_in;
    logic                   w_fill;
    logic                   w_fill_match;
    logic                   w_fill_ok;

    logic                   w_we;
    logic [IDX_W-1:0]       w_widx;
    logic [TAG_W-1:0]       w_wtag;
    logic [LINE_BITS-1:0]   w_wdata;
    logic [LINE_BYTES-1:0]  w_wmask;
    logic                   w_wfull;

    // Lookup follows the incoming access in IDLE and the parked access otherwise
    assign w_acc_addr = (r_state == IDLE)
                        ? (bus.raddr_valid ? bus.raddr[ADDR_W-1:OFF_W] : bus.waddr[ADDR_W-1:OFF_W])
                        : r_pend.addr[ADDR_W-1:OFF_W];
    assign w_acc_idx  = w_acc_addr[OFF_W +: IDX_W];
    assign w_acc_tag  = w_acc_addr[ADDR_W-1 -: TAG_W];
    assign w_pend_idx = r_pend.addr[OFF_W +: IDX_W];
    assign w_pend_tag = r_pend.addr[ADDR_W-1 -: TAG_W];
    assign w_fill_idx = bus.waddr[OFF_W +: IDX_W];
    assign w_fill_tag = bus.waddr[ADDR_W-1 -: TAG_W];

    assign w_hit        = w_lk_valid && (w_lk_tag == w_acc_tag);
    assign w_wr_in      = bus.waddr_valid && !bus.sent_repair;
    assign w_fill       = (r_state == FILL) && bus.waddr_valid && bus.sent_repair;
    assign w_fill_match = w_fill && (w_fill_idx == w_pend_idx);
    assign w_fill_ok    = r_pend.fill_seen || w_fill_match;

    // A fill arriving with resolve is not in the array yet, so the replay word bypasses from wdata
    assign w_src_line = w_fill_match ? bus.wdata : w_lk_line;
    assign w_word_sel = (r_state == IDLE) ? bus.raddr[OFF_W-1:2] : r_pend.addr[OFF_W-1:2];
    assign w_word     = w_src_line[{w_word_sel, 5'b0} +: 32];

    l1_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_ridx  (w_acc_idx),
        .o_tag   (w_lk_tag),
        .o_valid (w_lk_valid),
        .o_line  (w_lk_line),
        .i_we    (w_we),
        .i_widx  (w_widx),
        .i_wtag  (w_wtag),
        .i_wdata (w_wdata),
        .i_wmask (w_wmask),
        .i_full  (w_wfull)
    );

    // Single array write port shared by write hits, refills and write replays.
    // Fill+resolve of a pending write folds the store into the fill as one full-line write;
    // a write replay coinciding with a fill to another index takes the port over that stray fill.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_acc_idx;
        w_wtag  = w_acc_tag;
        w_wdata = bus.wdata;
        w_wmask = bus.wmask;
        w_wfull = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.raddr_valid && w_wr_in && w_hit) begin
                    w_we = 1'b1;
                end
            end
            FILL: begin
                if (bus.repair_resolved && r_pend.is_write && w_fill_match) begin
                    w_we    = 1'b1;
                    w_widx  = w_fill_idx;
                    w_wtag  = w_fill_tag;
                    w_wdata = byte_merge(bus.wdata, r_pend.wdata, r_pend.wmask);
                    w_wfull = 1'b1;
                end else if (bus.repair_resolved && r_pend.is_write && r_pend.fill_seen) begin
                    w_we    = 1'b1;
                    w_widx  = w_pend_idx;
                    w_wtag  = w_pend_tag;
                    w_wdata = r_pend.wdata;
                    w_wmask = r_pend.wmask;
                end else if (w_fill) begin
                    w_we    = 1'b1;
                    w_widx  = w_fill_idx;
                    w_wtag  = w_fill_tag;
                    w_wfull = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered response and repair-request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pend         <= '0;
            r_rdata        <= '0;
            r_rdata_valid  <= 1'b0;
            r_rd_req       <= 1'b0;
            r_wr_req       <= 1'b0;
            r_missed_raddr <= '0;
            r_missed_waddr <= '0;
        end else begin
            r_rdata_valid <= 1'b0;
            if (r_state != IDLE) begin
                assert (!(bus.raddr_valid || w_wr_in));
            end
            case (r_state)
                IDLE: begin
                    if (bus.raddr_valid) begin
                        if (w_hit) begin
                            r_rdata       <= w_word;
                            r_rdata_valid <= 1'b1;
                        end else begin
                            r_pend.addr      <= bus.raddr;
                            r_pend.is_write  <= 1'b0;
                            r_pend.wdata     <= '0;
                            r_pend.wmask     <= '0;
                            r_pend.fill_seen <= 1'b0;
                            r_missed_raddr   <= {bus.raddr[31:7], 7'b0};
                            r_rd_req         <= 1'b1;
                            r_state          <= RD_REQ;
                        end
                    end else if (w_wr_in && !w_hit) begin
                        r_pend.addr      <= bus.waddr;
                        r_pend.is_write  <= 1'b1;
                        r_pend.wdata     <= bus.wdata;
                        r_pend.wmask     <= bus.wmask;
                        r_pend.fill_seen <= 1'b0;
                        r_missed_waddr   <= {bus.waddr[31:7], 7'b0};
                        r_wr_req         <= 1'b1;
                        r_state          <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus.read_repair_req_acq) begin
                        r_rd_req <= 1'b0;
                        r_state  <= FILL;
                    end
                end
                WR_REQ: begin
                    if (bus.write_repair_req_acq) begin
                        r_wr_req <= 1'b0;
                        r_state  <= FILL;
                    end
                end
                FILL: begin
                    if (w_fill_match) begin
                        r_pend.fill_seen <= 1'b1;
                    end
                    if (bus.repair_resolved) begin
                        if (w_fill_ok) begin
                            if (!r_pend.is_write) begin
                                r_rdata       <= w_word;
                                r_rdata_valid <= 1'b1;
                            end
                            r_pend.fill_seen <= 1'b0;
                            r_state          <= IDLE;
                        end else if (r_pend.is_write) begin
                            r_wr_req <= 1'b1;
                            r_state  <= WR_REQ;
                        end else begin
                            r_rd_req <= 1'b1;
                            r_state  <= RD_REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rdata                = r_rdata;
    assign bus.rdata_valid          = r_rdata_valid;
    assign bus.read_repair_request  = r_rd_req;
    assign bus.write_repair_request = r_wr_req;
    assign bus.missed_raddr         = r_missed_raddr;
    assign bus.missed_waddr         = r_missed_waddr;

endmodule
